alu_pipe: RTL and testbench

- Two-stage pipelined ALU front end for the 8-bit datapath.
- Accepts operand pairs plus an opcode over a valid/ready handshake.
- Registers the inputs, computes the result through the combinational logic units (XOR, AND, OR, add/sub, shift), and holds the result and flags in an output register until the consumer takes them.
- Sits between the operand/instruction source and the register-file writeback.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_pipe_if.sv | 33 +++
 rtl/alu_core.sv | 79 +++++++
 rtl/alu_pipe.sv | 86 ++++++++
 tb/tb_alu_pipe.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: datapath sizes, opcode encoding,
// flag bit positions and a small signed-overflow helper.
package alu_pkg;

    // Default datapath geometry
    localparam int ALU_WIDTH = 8;
    localparam int ALU_OPW   = 3;
    localparam int NUM_FLAGS = 4;

    // Opcode encoding as seen on the instruction bus
    typedef enum logic [ALU_OPW-1:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_NOTA  = 3'b101,
        OP_SHL   = 3'b110,
        OP_PASSB = 3'b111
    } alu_op_e;

    // Bit positions inside the {N, Z, C, V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Two's-complement overflow from the operand and result sign bits.
    // Subtraction is treated as A + ~B + 1, so B's sign is inverted first.
    function automatic logic signedOverflow(input logic aMsb,
                                            input logic bMsb,
                                            input logic fMsb,
                                            input logic isSub);
        logic bEff;
        bEff = isSub ? ~bMsb : bMsb;
        return (aMsb == bEff) && (fMsb != aMsb);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between the instruction source, the ALU
// pipeline and the register-file writeback.
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [OPW-1:0]       in_op;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_f;
    logic [NUM_FLAGS-1:0] out_flags;

    // Producer of operations and consumer of results
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_f, out_flags
    );

    // The ALU pipeline itself
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_f, out_flags
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: one result and the {N, Z, C, V} flags for the
// selected opcode. All arithmetic wraps modulo 2^WIDTH.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [ALU_OPW-1:0]   i_op,
    output logic [WIDTH-1:0]     o_f,
    output logic [NUM_FLAGS-1:0] o_flags
);

    // One extra bit on the adder/subtractor exposes carry-out and borrow
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;

    // Bitwise logic units shared with the rest of the datapath
    logic [WIDTH-1:0]   w_and;
    logic [WIDTH-1:0]   w_or;
    logic [WIDTH-1:0]   w_xor;
    logic [WIDTH-1:0]   w_notA;
    logic [WIDTH-1:0]   w_shl;

    logic [WIDTH-1:0]   w_f;
    logic               w_c;
    logic               w_v;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    assign w_and  = i_a & i_b;
    assign w_or   = i_a | i_b;
    assign w_xor  = i_a ^ i_b;
    assign w_notA = ~i_a;
    assign w_shl  = {i_a[WIDTH-2:0], 1'b0};

    // Result mux; carry/overflow only mean something for add, sub and shift
    always_comb begin
        w_f = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_f = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = signedOverflow(i_a[WIDTH-1], i_b[WIDTH-1], w_sum[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                w_f = w_diff[WIDTH-1:0];
                w_c = w_diff[WIDTH];
                w_v = signedOverflow(i_a[WIDTH-1], i_b[WIDTH-1], w_diff[WIDTH-1], 1'b1);
            end
            OP_AND:   w_f = w_and;
            OP_OR:    w_f = w_or;
            OP_XOR:   w_f = w_xor;
            OP_NOTA:  w_f = w_notA;
            OP_SHL: begin
                w_f = w_shl;
                w_c = i_a[WIDTH-1];
            end
            OP_PASSB: w_f = i_b;
            default:  w_f = '0;
        endcase
    end

    // Pack the flag vector from the selected result
    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_N] = w_f[WIDTH-1];
        o_flags[FLAG_Z] = (w_f == '0);
        o_flags[FLAG_C] = w_c;
        o_flags[FLAG_V] = w_v;
    end

    assign o_f = w_f;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU front end. Stage 1 captures an operation from the source;
// stage 2 holds the computed result and flags until the writeback takes it.
// Up to two operations can be buffered while the consumer stalls.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);

    // Stage 1: captured operation
    logic                 r_s1Valid;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [OPW-1:0]       r_op;

    // Stage 2: result register presented to the consumer
    logic                 r_s2Valid;
    logic [WIDTH-1:0]     r_f;
    logic [NUM_FLAGS-1:0] r_flags;

    // Handshake and ALU wiring
    logic                 w_s1Adv;
    logic                 w_inReady;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_coreF;
    logic [NUM_FLAGS-1:0] w_coreFlags;

    // Stage 1 moves forward when stage 2 is empty or is being drained now,
    // which lets a full pipe still take a new op every cycle.
    assign w_s1Adv   = r_s1Valid && (!r_s2Valid || bus.out_ready);
    assign w_inReady = !rst && (!r_s1Valid || w_s1Adv);
    assign w_accept  = bus.in_valid && w_inReady;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_op    (r_op),
        .o_f     (w_coreF),
        .o_flags (w_coreFlags)
    );

    // Stage 1 register: load on accept, empty out when the op moves on
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_a       <= bus.in_a;
            r_b       <= bus.in_b;
            r_op      <= bus.in_op;
        end else if (w_s1Adv) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Stage 2 register: load the ALU result on advance, clear when consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_f       <= '0;
            r_flags   <= '0;
        end else if (w_s1Adv) begin
            r_s2Valid <= 1'b1;
            r_f       <= w_coreF;
            r_flags   <= w_coreFlags;
        end else if (bus.out_ready && r_s2Valid) begin
            r_s2Valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_s2Valid;
    assign bus.out_f     = r_f;
    assign bus.out_flags = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed reset/stream/backpressure
// sequences, a table of single-op vectors, and a randomized stream checked
// by a scoreboard fed from an arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   nChecks = 0;
    int   nFails  = 0;

    alu_pipe_if #(.WIDTH(8), .OPW(3)) bus();

    alu_pipe #(.WIDTH(8), .OPW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] expF;
        logic [3:0] expFlags;
    } vec_t;

    vec_t        vecs [13];
    logic [11:0] expQ [$];

    logic        holdValid = 1'b0;
    logic [7:0]  holdF;
    logic [3:0]  holdFlags;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference ALU written with plain integer arithmetic: returns {F, N, Z, C, V}
    function automatic logic [11:0] refAlu(input int a, input int b, input int op);
        int r, sa, sb, sr;
        logic c, v, n, z;
        logic [7:0] f;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            1: begin r = a - b; c = (a < b);   sr = sa - sb; v = (sr > 127) || (sr < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = a * 2; c = (a >= 128); end
            default: r = b;
        endcase
        r = r & 255;
        f = r[7:0];
        n = (r >= 128);
        z = (r == 0);
        return {f, n, z, c, v};
    endfunction

    // Scoreboard: queue expected results on input fire, compare on output fire,
    // and require held outputs to stay put while the consumer stalls
    always @(negedge clk) begin
        logic [11:0] exp;
        if (rst) begin
            expQ.delete();
            holdValid = 1'b0;
        end else begin
            if (holdValid) begin
                checkOutput("holdValid", bus.out_valid, 1);
                checkOutput("holdF", bus.out_f, holdF);
                checkOutput("holdFlags", bus.out_flags, holdFlags);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedOutput", bus.out_valid, 0);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("sbF", bus.out_f, exp[11:4]);
                    checkOutput("sbFlags", bus.out_flags, exp[3:0]);
                end
            end
            if (bus.in_valid && bus.in_ready)
                expQ.push_back(refAlu(int'(bus.in_a), int'(bus.in_b), int'(bus.in_op)));
            holdValid = bus.out_valid && !bus.out_ready;
            holdF     = bus.out_f;
            holdFlags = bus.out_flags;
        end
    end

    // Drive one op just after the next rising edge
    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
    endtask

    // Send one table vector with the consumer always ready; check latency and value
    task automatic runVector(input int idx);
        int   lat;
        logic got;
        applyStimulus(1'b1, vecs[idx].a, vecs[idx].b, vecs[idx].op);
        @(negedge clk);
        checkOutput($sformatf("vec%0dReady", idx), bus.in_ready, 1);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000);
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = c;
                got = 1'b1;
                break;
            end
        end
        checkOutput($sformatf("vec%0dLatency", idx), lat, 2);
        if (got) begin
            checkOutput($sformatf("vec%0dF", idx), bus.out_f, vecs[idx].expF);
            checkOutput($sformatf("vec%0dFlags", idx), bus.out_flags, vecs[idx].expFlags);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'hFF, 8'h01, OP_ADD,   8'h00, 4'b0110};
        vecs[1]  = '{8'h7F, 8'h01, OP_ADD,   8'h80, 4'b1001};
        vecs[2]  = '{8'h03, 8'h05, OP_SUB,   8'hFE, 4'b1010};
        vecs[3]  = '{8'h81, 8'h00, OP_SHL,   8'h02, 4'b0010};
        vecs[4]  = '{8'h00, 8'h33, OP_NOTA,  8'hFF, 4'b1000};
        vecs[5]  = '{8'h5A, 8'h00, OP_PASSB, 8'h00, 4'b0100};
        vecs[6]  = '{8'hAA, 8'h0F, OP_AND,   8'h0A, 4'b0000};
        vecs[7]  = '{8'hF0, 8'h0F, OP_OR,    8'hFF, 4'b1000};
        vecs[8]  = '{8'h80, 8'h01, OP_SUB,   8'h7F, 4'b0001};
        vecs[9]  = '{8'h80, 8'h80, OP_ADD,   8'h00, 4'b0111};
        vecs[10] = '{8'h05, 8'h05, OP_SUB,   8'h00, 4'b0100};
        vecs[11] = '{8'h55, 8'h55, OP_XOR,   8'h00, 4'b0100};
        vecs[12] = '{8'h40, 8'h00, OP_SHL,   8'h80, 4'b1000};

        // Reset held two cycles with an op offered: it must never be taken
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 8'd5;
        bus.in_b      = 8'd0;
        bus.in_op     = OP_ADD;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("rstInReady", bus.in_ready, 0);
        checkOutput("rstOutValid", bus.out_valid, 0);
        checkOutput("rstOutF", bus.out_f, 0);
        checkOutput("rstOutFlags", bus.out_flags, 0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("postRstInReady", bus.in_ready, 1);
        checkOutput("postRstOutValid", bus.out_valid, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rstOpDropped", bus.out_valid, 0);
        end

        // Back-to-back XOR stream with the consumer always ready
        applyStimulus(1'b1, 8'h01, 8'h01, OP_XOR);
        @(negedge clk);
        checkOutput("xorReady", bus.in_ready, 1);
        applyStimulus(1'b1, 8'hFF, 8'h7B, OP_XOR);
        @(negedge clk);
        checkOutput("xorFirstLatency", bus.out_valid, 0);
        applyStimulus(1'b1, 8'h87, 8'h0A, OP_XOR);
        @(negedge clk);
        checkOutput("xor0Valid", bus.out_valid, 1);
        checkOutput("xor0F", bus.out_f, 8'h00);
        checkOutput("xor0Flags", bus.out_flags, 4'b0100);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000);
        @(negedge clk);
        checkOutput("xor1Valid", bus.out_valid, 1);
        checkOutput("xor1F", bus.out_f, 8'h84);
        checkOutput("xor1Flags", bus.out_flags, 4'b1000);
        @(negedge clk);
        checkOutput("xor2Valid", bus.out_valid, 1);
        checkOutput("xor2F", bus.out_f, 8'h8D);
        checkOutput("xor2Flags", bus.out_flags, 4'b1000);
        @(negedge clk);
        checkOutput("xorDone", bus.out_valid, 0);

        // Table of single ops
        for (int i = 0; i < 13; i++)
            runVector(i);

        // Backpressure: only two ops fit, the third waits for stage 1 to free
        applyStimulus(1'b1, 8'h01, 8'h02, OP_ADD);
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bpReady1", bus.in_ready, 1);
        applyStimulus(1'b1, 8'hF0, 8'h0F, OP_OR);
        @(negedge clk);
        checkOutput("bpReady2", bus.in_ready, 1);
        checkOutput("bpNoOutYet", bus.out_valid, 0);
        applyStimulus(1'b1, 8'hAA, 8'h0F, OP_AND);
        @(negedge clk);
        checkOutput("bpFullReady", bus.in_ready, 0);
        checkOutput("bpFullValid", bus.out_valid, 1);
        checkOutput("bpFullF", bus.out_f, 8'h03);
        repeat (2) begin
            @(negedge clk);
            checkOutput("bpStallReady", bus.in_ready, 0);
            checkOutput("bpStallF", bus.out_f, 8'h03);
            checkOutput("bpStallFlags", bus.out_flags, 4'b0000);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bpRefillReady", bus.in_ready, 1);
        checkOutput("bpOut0F", bus.out_f, 8'h03);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000);
        @(negedge clk);
        checkOutput("bpOut1F", bus.out_f, 8'hFF);
        checkOutput("bpOut1Flags", bus.out_flags, 4'b1000);
        @(negedge clk);
        checkOutput("bpOut2Valid", bus.out_valid, 1);
        checkOutput("bpOut2F", bus.out_f, 8'h0A);
        checkOutput("bpOut2Flags", bus.out_flags, 4'b0000);
        @(negedge clk);
        checkOutput("bpDrained", bus.out_valid, 0);

        // Reset with two ops buffered: both are discarded
        applyStimulus(1'b1, 8'd10, 8'd20, OP_ADD);
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 8'd9, 8'd4, OP_SUB);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000);
        @(negedge clk);
        checkOutput("midRstFullReady", bus.in_ready, 0);
        checkOutput("midRstFullValid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("midRstValid", bus.out_valid, 0);
        checkOutput("midRstF", bus.out_f, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("midRstNoEmit", bus.out_valid, 0);
        end

        // Randomized traffic with random consumer stalls
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_a      = 8'($urandom_range(0, 255));
            bus.in_b      = 8'($urandom_range(0, 255));
            bus.in_op     = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !bus.out_valid)
                break;
        end
        checkOutput("drainQueueEmpty", expQ.size(), 0);
        checkOutput("drainOutValid", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
